// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          DEF_XLEN     = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of fetched {pc, instr} pairs with
// synchronous flush. Head contents are only meaningful while not empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [PW:0]     count_r;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
    end else if (flush) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
    end else begin
      if (push) begin
        wptr_r <= wptr_r + PW'(1'b1);
      end
      if (pop) begin
        rptr_r <= rptr_r + PW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PW+1)'(1'b1);
        2'b01:   count_r <= count_r - (PW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage carries no reset: stale data is never visible through head while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wptr_r] <= din;
    end
  end

  assign count = count_r;
  assign empty = (count_r == {(PW+1){1'b0}});
  assign head  = mem_r[rptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem requests, buffered valid/ready
// output and redirect flush. Optional FETCH_MISALIGN_EN adds fetch_misaligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [XLEN-1:0]    instr_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic               fetch_misaligned
`endif
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  logic            epoch_r;
  logic            inflight_epoch_r;

  logic [CW-1:0]   count_s;
  logic [CW:0]     occ_s;
  entry_t          head_s;
  entry_t          din_s;
  logic            empty_s;
  logic            pop_s;
  logic            push_s;
  logic            space_ok_s;
  logic            req_s;
  logic [XLEN-1:0] target_s;

`ifdef FETCH_MISALIGN_EN
  assign target_s = {redirect_pc[XLEN-1:2], 2'b00};
`else
  assign target_s = redirect_pc;
`endif

  // Handshake, request decision and buffer-head presentation.
  always_comb begin
    pop_s      = ~empty_s & instr_ready;
    occ_s      = (CW+1)'(count_s) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    space_ok_s = (occ_s < (CW+1)'(DEPTH));
    req_s      = reset & ~redirect & space_ok_s;
    // A response from an older epoch or one landing on a redirect is dropped.
    push_s     = inflight_r & (inflight_epoch_r == epoch_r) & ~redirect;
    din_s.pc    = inflight_pc_r;
    din_s.instr = imem_rdata;
    imem_req    = req_s;
    imem_addr   = pc_r;
    instr_valid = ~empty_s;
    if (empty_s) begin
      instruction = {INSTR_W{1'b0}};
      instr_pc    = {XLEN{1'b0}};
    end else begin
      instruction = head_s.instr;
      instr_pc    = head_s.pc;
    end
  end

  // PC, in-flight tracking and flush epoch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r             <= RESET_PC;
      inflight_r       <= 1'b0;
      inflight_pc_r    <= {XLEN{1'b0}};
      epoch_r          <= 1'b0;
      inflight_epoch_r <= 1'b0;
    end else if (redirect) begin
      pc_r       <= target_s;
      inflight_r <= 1'b0;
      epoch_r    <= ~epoch_r;
    end else if (req_s) begin
      pc_r             <= pc_r + PC_STEP;
      inflight_r       <= 1'b1;
      inflight_pc_r    <= pc_r;
      inflight_epoch_r <= epoch_r;
    end else begin
      inflight_r <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic misaligned_r;

  // Sticky flag for any redirect to a non-word-aligned target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned_r <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misaligned_r <= 1'b1;
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  assign fetch_misaligned = misaligned_r;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   (din_s),
    .count (count_s),
    .head  (head_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  bit          m_inflight;
  bit          m_mis;
  bit          mem_pend;
  logic [63:0] mem_addr;
  logic        last_req;
  logic        last_valid;
  logic [63:0] last_addr;
  logic [63:0] last_pc;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc       = 64'h0;
    m_ipc      = 64'h0;
    m_inflight = 1'b0;
    m_mis      = 1'b0;
    mem_pend   = 1'b0;
    mem_addr   = 64'h0;
  endtask

  // Called at a negedge: drive inputs, compare against the model, clock once.
  task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc);
    bit          exp_valid;
    bit          pop;
    bit          exp_req;
    ent_t        head;
    ent_t        e;
    logic [63:0] tgt;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = mem_pend ? word(mem_addr) : NOP_INSTR;
    #1;
    exp_valid = (mq.size() != 0);
    if (exp_valid) begin
      head = mq[0];
    end else begin
      head.pc    = 64'h0;
      head.instr = 32'h0;
    end
    pop     = exp_valid && rdy;
    exp_req = !rd && ((mq.size() + (m_inflight ? 1 : 0) - (pop ? 1 : 0)) < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 64'(instr_valid), 64'(exp_valid));
    check("instruction", 64'(instruction), 64'(head.instr));
    check("instr_pc", instr_pc, head.pc);
`ifdef FETCH_MISALIGN_EN
    check("fetch_misaligned", 64'(fetch_misaligned), 64'(m_mis));
`endif
    last_req   = imem_req;
    last_valid = instr_valid;
    last_addr  = imem_addr;
    last_pc    = instr_pc;
    mem_pend   = imem_req;
    mem_addr   = imem_addr;
    @(posedge clk);
`ifdef FETCH_MISALIGN_EN
    tgt = {rpc[63:2], 2'b00};
    if (rd && (rpc[1:0] != 2'b00)) m_mis = 1'b1;
`else
    tgt = rpc;
`endif
    if (rd) begin
      mq.delete();
      m_pc       = tgt;
      m_inflight = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inflight) begin
        e.pc    = m_ipc;
        e.instr = word(m_ipc);
        mq.push_back(e);
      end
      if (exp_req) begin
        m_ipc      = m_pc;
        m_pc       = m_pc + 64'd4;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    reset    = 1'b0;
    redirect = 1'b0;
    #1;
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_instr", 64'(instruction), 64'h0);
    check("rst_pc", instr_pc, 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    redirect_pc = 64'h0;
    imem_rdata  = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_valid", 64'(instr_valid), 64'h0);
    check("init_req", 64'(imem_req), 64'h0);
    check("init_instr", 64'(instruction), 64'h0);
    check("init_pc", instr_pc, 64'h0);
    reset = 1'b1;

    // Streaming from reset with decode always ready
    step(1'b1, 1'b0, 64'h0);
    check("p1_req0", 64'(last_req), 64'h1);
    check("p1_addr0", last_addr, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("p1_addr1", last_addr, 64'h4);
    check("p1_valid1", 64'(last_valid), 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("p1_valid2", 64'(last_valid), 64'h1);
    check("p1_pc2", last_pc, 64'h0);
    check("p1_addr2", last_addr, 64'h8);
    step(1'b1, 1'b0, 64'h0);
    check("p1_pc3", last_pc, 64'h4);
    step(1'b1, 1'b0, 64'h0);
    check("p1_pc4", last_pc, 64'h8);
    do_reset();

    // Back-pressure fills the buffer, then drains in order
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    check("p2_full_req", 64'(last_req), 64'h0);
    check("p2_head", last_pc, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    check("p2_full_req2", 64'(last_req), 64'h0);
    check("p2_head2", last_pc, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("p2_drain0", last_pc, 64'h0);
    check("p2_resume", last_addr, 64'h8);
    step(1'b1, 1'b0, 64'h0);
    check("p2_drain1", last_pc, 64'h4);
    step(1'b1, 1'b0, 64'h0);
    check("p2_drain2", last_pc, 64'h8);

    // Redirect during a stream, with a simultaneous pop
    step(1'b1, 1'b1, 64'h10);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("p3_pc10", last_pc, 64'h10);
    step(1'b1, 1'b1, 64'h100);
    check("p3_rd_req", 64'(last_req), 64'h0);
    check("p3_rd_valid", 64'(last_valid), 64'h1);
    step(1'b1, 1'b0, 64'h0);
    check("p3_flushed", 64'(last_valid), 64'h0);
    check("p3_addr", last_addr, 64'h100);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("p3_pc100", last_pc, 64'h100);

    // PC wraps modulo 2^64
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("wrap_addr", last_addr, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    check("wrap_pc0", last_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, 64'h0);
    check("wrap_pc1", last_pc, 64'h0);

    // Back-to-back redirects: the last target wins
    step(1'b1, 1'b1, 64'h200);
    step(1'b1, 1'b1, 64'h300);
    step(1'b1, 1'b0, 64'h0);
    check("rd2_addr", last_addr, 64'h300);

`ifdef FETCH_MISALIGN_EN
    step(1'b1, 1'b1, 64'h102);
    step(1'b1, 1'b0, 64'h0);
    check("mis_addr", last_addr, 64'h100);
    check("mis_flag", 64'(fetch_misaligned), 64'h1);
    step(1'b1, 1'b0, 64'h0);
    check("mis_sticky", 64'(fetch_misaligned), 64'h1);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)}
                                         : {32'h0, 32'($urandom)});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file stage. It holds the PC and issues word requests to a fixed 1-cycle-latency instruction memory.
- Returned words are buffered with their PCs and presented to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  XLEN  fetch address (= pc).
- imem_rdata  input  32  instruction word; valid exactly 1 cycle after imem_req.
- redirect  input  1  load new PC, flush pipeline.
- redirect_pc  input  XLEN  target PC for redirect.
- instr_valid  output  1  buffer head holds a valid instruction.
- instr_ready  input  1  decode accepts head this cycle.
- instruction  output  32  head instruction word.
- instr_pc  output  XLEN  PC of head instruction.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; buffer count=0; inflight=0; epoch=0.
  - imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
- State:
  - pc register.
  - inflight flag: a request issued last cycle.
  - inflight_pc.
  - DEPTH-entry FIFO of {pc, instr}.
- Definitions:
  - pop = instr_valid & instr_ready.
  - space_ok = (count + inflight − pop) < DEPTH.
- Request (combinational):
  - imem_req = reset & ~redirect & space_ok.
  - imem_addr = pc.
  - On request: pc <= pc + 4 (wraps modulo 2^XLEN); inflight <= 1; inflight_pc <= pc.
  - With no request: inflight <= 0.
- Response: the cycle after a request, {inflight_pc, imem_rdata} is pushed into the FIFO, unless that response was squashed.
- Output:
  - instr_valid = (count != 0).
  - instruction/instr_pc = FIFO head.
  - Both are 0 when empty.
  - Head is held stable while instr_valid & ~instr_ready.
- Latency: first request in the first cycle after reset release; instr_valid rises 2 cycles after the request (no bypass).
- Throughput: sustained 1 instr/cycle when instr_ready is held at 1.
- Full: count = DEPTH with no pop → imem_req=0. The push of an in-flight response is always guaranteed space by the space_ok rule.
- Redirect cycle:
  - No request is issued.
  - pc <= redirect_pc.
  - FIFO cleared (count <= 0).
  - Any response arriving this cycle or next from a pre-redirect request is discarded.
  - First request to redirect_pc occurs the following cycle.
- Redirect with simultaneous pop: the handshake completes (decode consumed the head); the flush still clears all entries.
- Redirect on consecutive cycles: the last redirect_pc wins.
- Push and pop in the same cycle: count is unchanged; ordering is preserved.
- Reset mid-operation: all state returns to reset values immediately; outstanding memory responses are ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - Set, sticky until reset, when redirect=1 and redirect_pc[1:0] != 0.
  - pc is loaded with redirect_pc with bits [1:0] forced to 0.
- Undefined: no extra port; redirect_pc is loaded unmodified.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32.
  - default XLEN, RESET_PC.
  - NOP_INSTR=32'h00000013, for bench use.
  - typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Synchronous DEPTH-entry FIFO with push, pop and flush.
  - Exports count, head entry and empty.
  - Same clk/reset convention.
- fetch_unit holds pc, inflight/epoch and the request logic.

Test Plan:
- Reset release, instr_ready=1, memory returns addr-tagged words → requests at 0x0, 0x4, 0x8 on consecutive cycles; instr_valid from cycle 2; then one instruction/cycle with instr_pc 0x0, 0x4, 0x8.
- instr_ready=0 after reset → buffer fills to DEPTH=2 (pc 0x0, 0x4); imem_req low; head stays 0x0; raising instr_ready resumes in order with no loss or duplicate.
- Steady stream at pc 0x10, redirect=1 with redirect_pc=0x100 → no request that cycle; instr_valid=0 next cycle; in-flight word for 0x10/0x14 never appears; next instr_pc is 0x100.
- Redirect while instr_valid & instr_ready → head counts as consumed; buffer empty next cycle; fetch resumes at redirect_pc.
- Reset asserted low mid-stream, asynchronously, between edges → instr_valid and imem_req drop immediately; first request after release is to RESET_PC.
- FETCH_MISALIGN_EN defined, redirect_pc=0x102 → fetch_misaligned=1 and stays 1; next imem_addr=0x100.
